// File: rtl/flop_scan_reader_pkg.sv
// Shared definitions for the flop scan reader: FSM state encoding,
// default snapshot width and the index-width helper.
package flop_scan_reader_pkg;

    // Default number of flop-state bits captured per snapshot.
    localparam int DEFAULT_WIDTH = 64;

    // Width of one transmitted unit.
    localparam int BYTE_W = 8;

    // Reader FSM: IDLE waits for a request, SEND streams the shadow bytes.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Byte index width: ceil(log2(nbytes)), never narrower than one bit.
    function automatic int idx_width(input int nbytes);
        if (nbytes <= 1) begin
            return 1;
        end
        return $clog2(nbytes);
    endfunction

endpackage : flop_scan_reader_pkg

// File: rtl/flop_shadow_reg.sv
// Shadow register holding one captured snapshot of the observed flops.
// Loads only on an explicit enable so bytes in flight never change.
module flop_shadow_reg
    import flop_scan_reader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;

    // Capture the observed vector on load; clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule : flop_shadow_reg

// File: rtl/flop_scan_reader.sv
// Flop scan reader: captures a WIDTH-bit flop-state vector on request and
// streams it out LSB byte first over a valid/ready byte interface.
// Requests that arrive while a snapshot is in flight are dropped and
// recorded in a sticky overrun flag. WIDTH must be a multiple of 8, >= 8.
module flop_scan_reader
    import flop_scan_reader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             snap_req,
    input  logic [WIDTH-1:0] snap_data,
    input  logic             tx_ready,
    input  logic             ovf_clr,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    output logic             tx_last,
    output logic             busy,
    output logic             ovf
);

    // Derived byte count and index geometry.
    localparam int NBYTES = WIDTH / BYTE_W;
    localparam int IDX_W  = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             ovf_q;
    logic             ovf_d;

    logic             load_shadow;
    logic             xfer;
    logic             drop_req;
    logic [WIDTH-1:0] shadow;
    logic [7:0]       byte_sel;

    // A new snapshot is only accepted from IDLE; in SEND it is an overrun,
    // including on the edge that transfers the last byte.
    assign load_shadow = (state_q == IDLE) && snap_req;
    assign drop_req    = (state_q == SEND) && snap_req;
    assign xfer        = (state_q == SEND) && tx_ready;

    flop_shadow_reg #(
        .WIDTH (WIDTH)
    ) u_shadow (
        .clk    (clk),
        .rst    (rst),
        .load_i (load_shadow),
        .data_i (snap_data),
        .data_o (shadow)
    );

    // Reader FSM and byte index: index restarts on capture and never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (snap_req) begin
                        state_q <= SEND;
                        idx_q   <= '0;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= IDLE;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    // Sticky overrun: a dropped request sets it and beats a same-edge clear.
    always_comb begin
        ovf_d = ovf_q;
        if (drop_req) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Overrun flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    // Select the shadow byte addressed by the current index.
    always_comb begin
        byte_sel = 8'h00;
        for (int b = 0; b < NBYTES; b++) begin
            if (idx_q == IDX_W'(b)) begin
                byte_sel = shadow[BYTE_W*b +: BYTE_W];
            end
        end
    end

    // Outputs decode registered state only; data is zeroed outside SEND.
    assign busy     = (state_q == SEND);
    assign tx_valid = busy;
    assign tx_data  = busy ? byte_sel : 8'h00;
    assign tx_last  = busy && (idx_q == LAST_IDX);
    assign ovf      = ovf_q;

endmodule : flop_scan_reader

// File: tb/tb_flop_scan_reader.sv
// Testbench for flop_scan_reader: directed scenarios plus a randomized run
// against a byte-queue reference model.
module tb_flop_scan_reader;

    localparam int WIDTH  = 64;
    localparam int NBYTES = WIDTH / 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             snap_req = 1'b0;
    logic [WIDTH-1:0] snap_data = '0;
    logic             tx_ready = 1'b0;
    logic             ovf_clr = 1'b0;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_last;
    logic             busy;
    logic             ovf;

    int n_tests = 0;
    int n_fail  = 0;

    flop_scan_reader #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .snap_req  (snap_req),
        .snap_data (snap_data),
        .tx_ready  (tx_ready),
        .ovf_clr   (ovf_clr),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_last   (tx_last),
        .busy      (busy),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are observed and inputs driven 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        snap_req = 1'b0;
        tx_ready = 1'b0;
        ovf_clr  = 1'b0;
        rst      = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({tx_valid, tx_last, busy, ovf, tx_data} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b l=%b b=%b o=%b d=%h, want all 0",
                     tx_valid, tx_last, busy, ovf, tx_data);
        end
    endtask

    // Capture a snapshot from IDLE: one-cycle request.
    task automatic capture(input logic [WIDTH-1:0] d);
        snap_req  = 1'b1;
        snap_data = d;
        tick();
        snap_req  = 1'b0;
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] d;
        d = 64'h0807060504030201;
        tx_ready = 1'b1;
        capture(d);
        for (int i = 0; i < NBYTES; i++) begin
            n_tests++;
            if (tx_valid !== 1'b1 || busy !== 1'b1 || tx_data !== 8'(i + 1) ||
                tx_last !== (i == NBYTES - 1)) begin
                n_fail++;
                $display("FAIL basic_byte%0d: got v=%b b=%b d=%h l=%b, want v=1 b=1 d=%h l=%b",
                         i, tx_valid, busy, tx_data, tx_last, 8'(i + 1), (i == NBYTES - 1));
            end
            snap_data = $urandom;
            tick();
        end
        n_tests++;
        if (busy !== 1'b0 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: got b=%b v=%b, want 0 0", busy, tx_valid);
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        int k;
        int c;
        k = 0;
        c = 0;
        tx_ready = 1'b0;
        capture(64'h0807060504030201);
        while (k < NBYTES && c < 100) begin
            tx_ready = (c % 3 == 0);
            n_tests++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(k + 1) || tx_last !== (k == NBYTES - 1)) begin
                n_fail++;
                $display("FAIL bp_cycle%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                         c, tx_valid, tx_data, tx_last, 8'(k + 1), (k == NBYTES - 1));
            end
            if (tx_ready) k++;
            c++;
            tick();
        end
        n_tests++;
        if (k != NBYTES || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_count: got transfers=%0d busy=%b, want %0d 0", k, busy, NBYTES);
        end
        idle_inputs();
    endtask

    task automatic test_overrun_mid();
        tx_ready = 1'b1;
        capture(64'h0807060504030201);
        for (int i = 0; i < NBYTES; i++) begin
            n_tests++;
            if (tx_data !== 8'(i + 1) || tx_valid !== 1'b1 || ovf !== (i >= 4)) begin
                n_fail++;
                $display("FAIL ovr_byte%0d: got d=%h v=%b o=%b, want d=%h v=1 o=%b",
                         i, tx_data, tx_valid, ovf, 8'(i + 1), (i >= 4));
            end
            snap_req = (i == 3);
            snap_data = (i == 3) ? {WIDTH{1'b1}} : snap_data;
            tick();
        end
        snap_req = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_end: got b=%b o=%b, want 0 1", busy, ovf);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_tests++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovr_clear: got o=%b, want 0", ovf);
        end
        idle_inputs();
    endtask

    task automatic test_overrun_last();
        tx_ready = 1'b1;
        capture(64'h0807060504030201);
        for (int i = 0; i < NBYTES - 1; i++) tick();
        n_tests++;
        if (tx_last !== 1'b1 || tx_data !== 8'h08) begin
            n_fail++;
            $display("FAIL last_ready: got l=%b d=%h, want 1 08", tx_last, tx_data);
        end
        snap_req  = 1'b1;
        snap_data = 64'h1122334455667788;
        ovf_clr   = 1'b1;
        tick();
        snap_req = 1'b0;
        ovf_clr  = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || tx_valid !== 1'b0 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL last_drop: got b=%b v=%b o=%b, want 0 0 1", busy, tx_valid, ovf);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL last_stay_idle: got b=%b o=%b, want 0 1", busy, ovf);
        end
        ovf_clr = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        tx_ready = 1'b1;
        capture(64'h0807060504030201);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        tick();
        n_tests++;
        if (tx_data !== 8'h03 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got d=%h o=%b, want 03 1", tx_data, ovf);
        end
        rst = 1'b1;
        snap_req = 1'b1;
        ovf_clr = 1'b0;
        tick();
        rst = 1'b0;
        snap_req = 1'b0;
        n_tests++;
        if ({tx_valid, tx_last, busy, ovf, tx_data} !== 12'h000) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got v=%b l=%b b=%b o=%b d=%h, want all 0",
                     tx_valid, tx_last, busy, ovf, tx_data);
        end
        capture(64'h00000000000000A5);
        for (int i = 0; i < NBYTES; i++) begin
            n_tests++;
            if (tx_data !== ((i == 0) ? 8'hA5 : 8'h00) || tx_last !== (i == NBYTES - 1)) begin
                n_fail++;
                $display("FAIL rstmid_new%0d: got d=%h l=%b, want d=%h l=%b",
                         i, tx_data, tx_last, (i == 0) ? 8'hA5 : 8'h00, (i == NBYTES - 1));
            end
            tick();
        end
        idle_inputs();
    endtask

    // Random traffic against a model that keeps the pending bytes in a queue.
    task automatic test_random();
        logic [7:0]       mq[$];
        logic             m_ovf;
        logic             m_busy;
        logic [WIDTH-1:0] d;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        for (int c = 0; c < 600; c++) begin
            m_busy = (mq.size() != 0);
            n_tests++;
            if (tx_valid !== m_busy || busy !== m_busy || ovf !== m_ovf ||
                tx_data !== (m_busy ? mq[0] : 8'h00) ||
                tx_last !== (mq.size() == 1)) begin
                n_fail++;
                $display("FAIL rand_c%0d: got v=%b b=%b o=%b d=%h l=%b, want v=%b o=%b d=%h l=%b",
                         c, tx_valid, busy, ovf, tx_data, tx_last, m_busy, m_ovf,
                         m_busy ? mq[0] : 8'h00, (mq.size() == 1));
            end
            rst       = ($urandom_range(0, 59) == 0);
            snap_req  = ($urandom_range(0, 4) == 0);
            tx_ready  = ($urandom_range(0, 2) != 0);
            ovf_clr   = ($urandom_range(0, 9) == 0);
            d         = {$urandom, $urandom};
            snap_data = d;
            if (rst) begin
                mq.delete();
                m_ovf = 1'b0;
            end else begin
                if (m_busy && snap_req) m_ovf = 1'b1;
                else if (ovf_clr) m_ovf = 1'b0;
                if (m_busy && tx_ready) void'(mq.pop_front());
                if (!m_busy && snap_req) begin
                    for (int b = 0; b < NBYTES; b++) mq.push_back(d[8*b +: 8]);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        tick();
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun_mid();
        test_overrun_last();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_flop_scan_reader

// File: doc/flop_scan_reader.md
FLOP_SCAN_READER -- requirements
Module: flop_scan_reader

Interface
REQ-001 Parameter: WIDTH, default 64, number of flop-state bits snapshotted; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter: NBYTES, default WIDTH/8, byte count per snapshot; derived, not overridden.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 snap_req  input  1  one-cycle request to capture snap_data.
REQ-006 snap_data  input  WIDTH  parallel flop-state vector under observation.
REQ-007 tx_ready  input  1  downstream consumer accepts the current byte.
REQ-008 ovf_clr  input  1  clears the sticky overrun flag.
REQ-009 tx_valid  output  1  tx_data holds a valid snapshot byte.
REQ-010 tx_data  output  8  snapshot byte, least-significant byte first.
REQ-011 tx_last  output  1  the current byte is byte NBYTES-1.
REQ-012 busy  output  1  a snapshot is held or being sent.
REQ-013 ovf  output  1  sticky flag: a snap_req was dropped.

Function
REQ-014 FSM states SHALL be IDLE and SEND; reset state is IDLE.
REQ-015 IDLE with snap_req=1 at edge N: the block SHALL latch snap_data into a WIDTH-bit shadow register, set byte index to 0, and enter SEND.
REQ-016 Latency: tx_valid and busy SHALL be 1 in the cycle after edge N; there is no combinational path from snap_req to outputs.
REQ-017 In SEND, tx_valid=1 and tx_data=shadow[8*idx+7 : 8*idx].
REQ-018 tx_last SHALL equal (idx == NBYTES-1) && tx_valid.
REQ-019 Handshake: a byte transfers on an edge with tx_valid=1 and tx_ready=1; idx then increments by 1.
REQ-020 With tx_ready=0, tx_data, tx_last and idx SHALL hold stable; tx_valid SHALL NOT drop before transfer.
REQ-021 A transfer with tx_last=1 SHALL return the FSM to IDLE; tx_valid=0 and busy=0 on the next cycle.
REQ-022 idx SHALL be ceil(log2(NBYTES)) bits wide (minimum 1) and SHALL never exceed NBYTES-1; there is no wrap.
REQ-023 snap_req while in SEND SHALL be ignored, the shadow register SHALL remain unchanged, and ovf SHALL be set.
REQ-024 snap_req coincident with the last-byte transfer SHALL be dropped and SHALL set ovf; IDLE is entered.
REQ-025 ovf_clr=1 SHALL clear ovf on the next edge; if ovf_clr and a set condition occur on the same edge, the set wins.
REQ-026 Changes to snap_data after capture SHALL NOT affect bytes in flight.
REQ-027 busy SHALL equal (state == SEND).

Reset
REQ-028 rst=1 at an edge SHALL force state=IDLE, idx=0, shadow=0, ovf=0, so that tx_valid=0, tx_last=0, tx_data=0 and busy=0 in the following cycle.
REQ-029 rst mid-SEND SHALL abort the snapshot with no further bytes; rst has priority over snap_req, tx_ready and ovf_clr.
REQ-030 The reset value of every output SHALL be 0.

Structure
REQ-031 State encodings (IDLE=1'b0, SEND=1'b1) and the default WIDTH SHALL reside in the shared global definitions include file.
REQ-032 The shadow register SHALL be one sub-module, flop_shadow_reg (WIDTH-bit, load-enable, synchronous active-high reset); the FSM, index and ovf SHALL be local to this module.
REQ-033 The block SHALL contain no latches, no asynchronous logic and a single clock domain.

Verification
REQ-034 Reset, then snap_req=1 for 1 cycle with snap_data=64'h0807060504030201 and tx_ready=1 -> tx_data 01,02,...,08 on 8 consecutive cycles, tx_last only on 08, then busy=0.
REQ-035 Same capture with tx_ready toggling 1,0,0,1,... -> each byte held stable while tx_ready=0, byte order unchanged, and exactly 8 transfers.
REQ-036 snap_req again at byte 3 with snap_data=64'hFFFF_FFFF_FFFF_FFFF -> remaining bytes are still 04..08, and ovf=1 from the next cycle; ovf_clr=1 -> ovf=0.
REQ-037 snap_req coincident with the last-byte transfer -> IDLE entered, no new snapshot, ovf=1; same-edge ovf_clr and set -> ovf stays 1.
REQ-038 rst=1 for 1 cycle after byte 2 transfers -> all outputs 0 next cycle; a new snap_req with 64'hA5 -> first byte A5, idx restarted from 0.
